// File: rtl/multicycle_control.sv
// ============================================================================
//  Module   : multicycle_control
//  Brief    : Main control FSM for a multicycle MIPS datapath with
//             memory-ready stalls.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_RST    = 4'd15
    } state_t;

    state_t r_state;

    // State register; the asynchronous reset makes every state-decoded
    // output fall to zero without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RST;
        end else begin
            case (r_state)
                S_RST: r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)
                        r_state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        c_OP_LW,
                        c_OP_SW:   r_state <= S_MEMADR;
                        c_OP_R:    r_state <= S_EXEC;
                        c_OP_BEQ:  r_state <= S_BRANCH;
                        c_OP_ADDI: r_state <= S_ADDIEX;
                        c_OP_J:    r_state <= S_JUMP;
                        default:   r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (opcode == c_OP_LW)
                        r_state <= S_MEMRD;
                    else
                        r_state <= S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready)
                        r_state <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (mem_ready)
                        r_state <= S_FETCH;
                end
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB,
                S_ALUWB,
                S_BRANCH,
                S_ADDIWB,
                S_JUMP:   r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    logic w_opcode_known;

    always_comb begin
        w_opcode_known = 1'b0;
        case (opcode)
            c_OP_R, c_OP_LW, c_OP_SW,
            c_OP_BEQ, c_OP_ADDI, c_OP_J: w_opcode_known = 1'b1;
            default:                     w_opcode_known = 1'b0;
        endcase
    end

    // Moore decode of the controls; the handshake-qualified strobes are the
    // only terms that look at mem_ready.
    always_comb begin
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = ~w_opcode_known;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            default: begin
                MemRead = 1'b0;
            end
        endcase
    end

    assign state = r_state;

endmodule

`default_nettype wire
